// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: shared defaults, chunk sizing and mode encoding for pipelined_addsub.
package pipelined_addsub_pkg;
  localparam int WIDTH_D = 16;
  localparam int STAGES_D = 4;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  function automatic int chunk(input int w, input int s);
    return w / s;
  endfunction
endpackage

// File: rtl/pipelined_addsub_slice.sv
// addsub_slice: W-bit ripple full-adder chain exposing carry-out and carry into the msb.
module addsub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar j = 0; j < W; j++) begin : fa
    assign s[j] = a[j] ^ b[j] ^ c[j];
    assign c[j+1] = (a[j] & b[j]) | (c[j] & (a[j] ^ b[j]));
  end
  assign cout = c[W];
  assign cmsb = c[W-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: carry-registered add/sub pipeline with valid/ready stream; out_ovf present under ADDSUB_OVF_EN.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int STAGES = STAGES_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef ADDSUB_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);
  localparam int C = chunk(WIDTH, STAGES);
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar i = 0; i < STAGES; i++) begin : g
    localparam int L = WIDTH - i * C;
    logic [L-1:0] xa, xb;
    logic xc, xv;
    logic [C-1:0] ns;
    logic nc, nm;
    logic [(i+1)*C-1:0] ys;
    logic v, c;
    logic [(i+1)*C-1:0] s;
    if (i == 0) begin : h
      assign xa = in_a;
      assign xb = (in_sub == MODE_SUB) ? ~in_b : in_b;
      assign xc = (in_sub == MODE_SUB) ? ~in_cin : in_cin;
      assign xv = in_valid;
      assign ys = ns;
    end else begin : h
      assign xa = g[i-1].k.ra;
      assign xb = g[i-1].k.rb;
      assign xc = g[i-1].c;
      assign xv = g[i-1].v;
      assign ys = {ns, g[i-1].s};
    end
    addsub_slice #(.W(C)) u_slice (
      .a(xa[C-1:0]), .b(xb[C-1:0]), .cin(xc), .s(ns), .cout(nc), .cmsb(nm)
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v <= 1'b0;
        c <= 1'b0;
        s <= '0;
      end else if (adv) begin
        v <= xv;
        c <= nc;
        s <= ys;
      end
    // Skew registers carry only the operand bits still owed to later chunks
    if (i < STAGES - 1) begin : k
      logic [L-C-1:0] ra, rb;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          ra <= '0;
          rb <= '0;
        end else if (adv) begin
          ra <= xa[L-1:C];
          rb <= xb[L-1:C];
        end
    end
`ifdef ADDSUB_OVF_EN
    if (i == STAGES - 1) begin : o
      logic ro;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ro <= 1'b0;
        else if (adv) ro <= nc ^ nm;
    end
`endif
  end
  assign out_valid = g[STAGES-1].v;
  assign out_sum = g[STAGES-1].s;
  assign out_cout = g[STAGES-1].c;
`ifdef ADDSUB_OVF_EN
  assign out_ovf = g[STAGES-1].o.ro;
`endif
endmodule
